// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and its user.
// The master drives restart and the PLL's locked flag; the slave is the sequencer.
interface pll_lock_sequencer_if;
  logic       restart;
  logic       pll_locked;
  logic       pll_rst;
  logic       clk_ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] loss_count;
  logic [2:0] state;

  modport master (
    output restart, pll_locked,
    input  pll_rst, clk_ready, fault, retry_count, loss_count, state
  );

  modport slave (
    input  restart, pll_locked,
    output pll_rst, clk_ready, fault, retry_count, loss_count, state
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Audio PLL bring-up sequencer: holds PLL reset, qualifies a synchronised lock,
// retries on timeout or lock loss and latches a fault after repeated failures.
//
// state     | meaning
// RESET_PLL | PLL reset asserted for RST_CYCLES
// WAIT_LOCK | reset released, waiting up to LOCK_TIMEOUT for lock
// QUALIFY   | lock must stay high for STABLE_CYCLES
// RUN       | clock qualified, clk_ready high
// FAULT     | retries exhausted, PLL held in reset until restart
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_sequencer_if.slave  bus
);

  localparam logic [2:0] RESET_PLL = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] QUALIFY   = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] FAULT     = 3'd4;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_rst_q, pll_rst_d;
  logic             clk_ready_q, clk_ready_d;
  logic             fault_q, fault_d;
  logic             sync1_q, lock_s_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock wins over a timeout landing in the same cycle.
        if (lock_s_q) begin
          state_d = QUALIFY;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = FAULT;
          end else begin
            state_d = RESET_PLL;
            retry_d = retry_q + 2'd1;
          end
        end
      end
      QUALIFY: begin
        if (!lock_s_q) begin
          cnt_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = FAULT;
          end else begin
            state_d = RESET_PLL;
            retry_d = retry_q + 2'd1;
          end
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s_q) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          if (retry_q == RETRY_MAX) begin
            state_d = FAULT;
          end else begin
            state_d = RESET_PLL;
            retry_d = retry_q + 2'd1;
          end
        end
      end
      FAULT: begin
        cnt_d = '0;
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    // restart overrides everything except the loss tally already computed above.
    if (bus.restart) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end

    pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAULT);
    clk_ready_d = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      fault_q     <= 1'b0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      clk_ready_q <= clk_ready_d;
      fault_q     <= fault_d;
      sync1_q     <= bus.pll_locked;
      lock_s_q    <= sync1_q;
    end
  end

  assign bus.state       = state_q;
  assign bus.pll_rst     = pll_rst_q;
  assign bus.clk_ready   = clk_ready_q;
  assign bus.fault       = fault_q;
  assign bus.retry_count = retry_q;
  assign bus.loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters
// (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2).
module tb_pll_lock_sequencer;
  logic refclk;
  logic rst;
  int   passed;
  int   total;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .CNT_W         (16)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.state !== tgt && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.state), 32'(tgt));
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst            = 1'b1;
    bus.restart    = 1'b0;
    bus.pll_locked = 1'b0;
    tick(2);

    check("rst_state",     32'(bus.state), 0);
    check("rst_pll_rst",   32'(bus.pll_rst), 1);
    check("rst_clk_ready", 32'(bus.clk_ready), 0);
    check("rst_fault",     32'(bus.fault), 0);
    check("rst_retry",     32'(bus.retry_count), 0);
    check("rst_loss",      32'(bus.loss_count), 0);

    // Nominal bring-up
    rst = 1'b0;
    tick(3);
    check("nom_pll_rst_held", 32'(bus.pll_rst), 1);
    tick(1);
    check("nom_pll_rst_fall", 32'(bus.pll_rst), 0);
    check("nom_wait_lock",    32'(bus.state), 1);
    tick(6);
    bus.pll_locked = 1'b1;
    tick(2);
    check("nom_still_wait", 32'(bus.state), 1);
    tick(1);
    check("nom_qualify", 32'(bus.state), 2);
    tick(7);
    check("nom_not_ready", 32'(bus.clk_ready), 0);
    tick(1);
    check("nom_run",       32'(bus.state), 3);
    check("nom_clk_ready", 32'(bus.clk_ready), 1);
    check("nom_retry",     32'(bus.retry_count), 0);

    // Lock loss in RUN
    bus.pll_locked = 1'b0;
    tick(2);
    check("loss_ready_hold", 32'(bus.clk_ready), 1);
    tick(1);
    check("loss_ready_fall", 32'(bus.clk_ready), 0);
    check("loss_count1",     32'(bus.loss_count), 1);
    check("loss_state",      32'(bus.state), 0);
    check("loss_retry",      32'(bus.retry_count), 1);
    bus.pll_locked = 1'b1;
    wait_state(3'd3, 40, "loss_rerun");
    check("loss_rerun_retry", 32'(bus.retry_count), 0);

    // Restart coinciding with lock loss: loss counted, no retry increment
    bus.pll_locked = 1'b0;
    tick(2);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    check("simul_state", 32'(bus.state), 0);
    check("simul_loss",  32'(bus.loss_count), 2);
    check("simul_retry", 32'(bus.retry_count), 0);
    bus.pll_locked = 1'b1;
    wait_state(3'd3, 40, "simul_rerun");

    // Restart pulse in RUN
    bus.restart = 1'b1;
    tick(1);
    bus.restart    = 1'b0;
    bus.pll_locked = 1'b0;
    check("rrun_state",   32'(bus.state), 0);
    check("rrun_ready",   32'(bus.clk_ready), 0);
    check("rrun_pll_rst", 32'(bus.pll_rst), 1);
    check("rrun_loss",    32'(bus.loss_count), 2);

    // Never locks: three attempts of 4+20 cycles, then FAULT
    tick(23);
    check("nl_a1_wait", 32'(bus.state), 1);
    tick(1);
    check("nl_a1_fail",  32'(bus.state), 0);
    check("nl_retry1",   32'(bus.retry_count), 1);
    tick(24);
    check("nl_a2_fail",  32'(bus.state), 0);
    check("nl_retry2",   32'(bus.retry_count), 2);
    tick(23);
    check("nl_a3_wait", 32'(bus.state), 1);
    tick(1);
    check("nl_fault_state", 32'(bus.state), 4);
    check("nl_fault",       32'(bus.fault), 1);
    check("nl_fault_prst",  32'(bus.pll_rst), 1);
    tick(500);
    check("nl_fault_sticky", 32'(bus.state), 4);
    check("nl_fault_flag",   32'(bus.fault), 1);

    // Restart pulse in FAULT
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    check("rflt_state", 32'(bus.state), 0);
    check("rflt_fault", 32'(bus.fault), 0);
    check("rflt_retry", 32'(bus.retry_count), 0);
    check("rflt_loss",  32'(bus.loss_count), 2);

    // Glitchy lock: 5 high, 1 low, then high
    wait_state(3'd1, 10, "gl_wait_lock");
    bus.pll_locked = 1'b1;
    tick(5);
    check("gl_qualify", 32'(bus.state), 2);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    wait_state(3'd0, 8, "gl_abort");
    check("gl_retry1", 32'(bus.retry_count), 1);
    wait_state(3'd3, 40, "gl_run");
    check("gl_retry0", 32'(bus.retry_count), 0);
    check("gl_ready",  32'(bus.clk_ready), 1);

    // Async reset mid-QUALIFY
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    wait_state(3'd2, 20, "ar_qualify");
    tick(2);
    #2;
    rst = 1'b1;
    #1;
    check("ar_state",   32'(bus.state), 0);
    check("ar_pll_rst", 32'(bus.pll_rst), 1);
    check("ar_ready",   32'(bus.clk_ready), 0);
    check("ar_loss",    32'(bus.loss_count), 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check("ar_after_release", 32'(bus.state), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
